pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central valid/allow-in sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Owns per-stage valid bits and generates the over/allow-in handshakes that gate the inter-stage bus registers (if_id, id_ex, ex_mem, mem_wb).
- Detects load-use hazards in ID.
- Applies branch-redirect flushes from EX.
- Accepts stage-local ready_go inputs for multi-cycle EX and MEM operations.

Parameters:
- REG_AW, 5, register index width for hazard compare.
- CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset; deassertion synchronous to clk_i
- if_ready_go_i  in  1  IF fetch data available
- ex_ready_go_i  in  1  EX op complete (low during multi-cycle div/mul)
- mem_ready_go_i  in  1  MEM access complete
- id_rs1_i  in  REG_AW  ID source reg 1
- id_rs2_i  in  REG_AW  ID source reg 2
- id_use_rs1_i  in  1  ID inst reads rs1
- id_use_rs2_i  in  1  ID inst reads rs2
- ex_rd_i  in  REG_AW  EX dest reg
- ex_is_load_i  in  1  EX inst is a load
- ex_flush_i  in  1  EX branch/jump taken; redirect
- if_allow_in_o, id_allow_in_o, ex_allow_in_o, mem_allow_in_o  out  1 each  stage can accept
- if_over_o, id_over_o, ex_over_o, mem_over_o  out  1 each  stage done, may pass down
- id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o  out  1 each  stage holds live inst
- ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o  out  1 each  load-enable for the bus reg feeding that stage
- load_use_stall_o  out  1  ID held by load-use hazard
- if_redirect_o  out  1  PC must take branch target; discard current fetch
- stall_cnt_o, flush_cnt_o  out  CNT_W each  perf counters (present only with PIPE_PERF_CNT_EN)

Behaviour:
- Reset (async, rst_n_i=0): if_valid, id_valid, ex_valid, mem_valid, wb_valid = 0; counters = 0.
- Reset mid-operation discards all in-flight instructions.
- First cycle after deassertion: if_valid <= 1 and stays 1 thereafter.
- WB always completes: wb_allow_in = 1; wb_ready_go = 1.
- Hazard: load_use = ex_valid & ex_is_load_i & (ex_rd_i != 0) & ((id_use_rs1_i & rs1 == rd) | (id_use_rs2_i & rs2 == rd)).
- id_ready_go = ~load_use.
- load_use_stall_o = id_valid & load_use.
- Per stage S with successor N:
  - S_over = S_valid & S_ready_go
  - S_allow_in = ~S_valid | (S_ready_go & N_allow_in)
- All handshake outputs are combinational from current state and inputs.
- ld_N = S_over & N_allow_in. The bus register for N captures exactly on that cycle.
- Valid update on clk edge, when N_allow_in: N_valid <= S_over & ~kill_N.
- When ~N_allow_in: N_valid holds.
- Flush, effective when fl = ex_flush_i & ex_valid (ex_flush_i with ex_valid=0 is ignored):
  - kill_ID = fl: id_valid <= 0 regardless of id_allow_in.
  - kill_EX = fl: ex_valid does not receive ID's instruction; it becomes 0 if ex_allow_in, else holds.
  - if_redirect_o = fl.
  - The flushing EX instruction itself proceeds to MEM normally.
- Flush beats load-use stall in the same cycle (the stalled ID inst is killed).
- A stall never drops an instruction. A stage holding valid with ~allow_in keeps its valid bit and bus register unchanged.
- Backpressure propagates combinationally: mem_ready_go_i=0 with mem_valid=1 deasserts mem_allow_in, ex_allow_in (if ex_valid), and onward.
- Latency: an unstalled instruction advances one stage per cycle. IF over to WB valid takes 4 edges.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments each cycle load_use_stall_o = 1.
  - flush_cnt_o increments each cycle fl = 1.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports and counters are absent.
- Handshake behaviour is identical either way.

Test Plan:
- Reset release, all ready_go=1, no hazards -> if_valid=1 at cycle 1; id/ex/mem/wb_valid rise on cycles 2/3/4/5; ld_* each 1 every cycle thereafter.
- EX load with rd=5, ID reads rs1=5 -> load_use_stall_o=1 for exactly 1 cycle; ex_valid=0 bubble next cycle; ld_id_o=0 during stall; ID inst reaches EX one cycle later.
- Same hazard with ex_rd_i=0 -> no stall.
- ex_flush_i=1 with ex_valid=1 -> if_redirect_o=1; next cycle id_valid=0, ex_valid=0, mem_valid=1 (the branch).
- ex_flush_i=1 with ex_valid=0 -> ignored.
- ex_ready_go_i=0 for 3 cycles -> ex_valid held 1, id_allow_in=0, if_allow_in=0 when both full; mem_valid=0 for 3 cycles; resumes with no lost or duplicated instruction.
- Flush and load-use together -> ID killed, stall_cnt +1, flush_cnt +1 (with PIPE_PERF_CNT_EN).
- rst_n_i low mid-stream -> all valids 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/allow-in sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// Owns the per-stage valid bits, produces over/allow-in/load-enable handshakes,
// detects load-use hazards in ID and applies branch-redirect flushes from EX.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_ready_go_i,
  input  logic              ex_ready_go_i,
  input  logic              mem_ready_go_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_flush_i,
  output logic              if_allow_in_o,
  output logic              id_allow_in_o,
  output logic              ex_allow_in_o,
  output logic              mem_allow_in_o,
  output logic              if_over_o,
  output logic              id_over_o,
  output logic              ex_over_o,
  output logic              mem_over_o,
  output logic              id_valid_o,
  output logic              ex_valid_o,
  output logic              mem_valid_o,
  output logic              wb_valid_o,
  output logic              ld_id_o,
  output logic              ld_ex_o,
  output logic              ld_mem_o,
  output logic              ld_wb_o,
  output logic              load_use_stall_o,
  output logic              if_redirect_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  logic if_valid_q,  if_valid_d;
  logic id_valid_q,  id_valid_d;
  logic ex_valid_q,  ex_valid_d;
  logic mem_valid_q, mem_valid_d;
  logic wb_valid_q,  wb_valid_d;

  logic load_use;
  logic id_ready_go;
  logic fl;
  logic if_over, id_over, ex_over, mem_over;
  logic if_allow_in, id_allow_in, ex_allow_in, mem_allow_in;

  // Load-use hazard: EX load whose destination feeds a source read in ID
  always_comb begin
    load_use = ex_valid_q & ex_is_load_i & (ex_rd_i != '0) &
               ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    id_ready_go = ~load_use;
    fl          = ex_flush_i & ex_valid_q;
  end

  // Handshakes: backpressure ripples from WB (always accepting) up to IF
  always_comb begin
    mem_allow_in = ~mem_valid_q | mem_ready_go_i;
    ex_allow_in  = ~ex_valid_q  | (ex_ready_go_i & mem_allow_in);
    id_allow_in  = ~id_valid_q  | (id_ready_go & ex_allow_in);
    if_allow_in  = ~if_valid_q  | (if_ready_go_i & id_allow_in);

    if_over  = if_valid_q  & if_ready_go_i;
    id_over  = id_valid_q  & id_ready_go;
    ex_over  = ex_valid_q  & ex_ready_go_i;
    mem_over = mem_valid_q & mem_ready_go_i;
  end

  // Next-state valids; a flush kills ID outright and denies EX the ID instruction
  always_comb begin
    if_valid_d  = 1'b1;
    id_valid_d  = id_valid_q;
    ex_valid_d  = ex_valid_q;
    mem_valid_d = mem_valid_q;
    wb_valid_d  = mem_over;
    if (fl) begin
      id_valid_d = 1'b0;
    end else if (id_allow_in) begin
      id_valid_d = if_over;
    end
    if (ex_allow_in) begin
      ex_valid_d = id_over & ~fl;
    end
    if (mem_allow_in) begin
      mem_valid_d = ex_over;
    end
  end

  // Valid bit registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_valid_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      if_valid_q  <= if_valid_d;
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  // Output mapping
  always_comb begin
    if_allow_in_o    = if_allow_in;
    id_allow_in_o    = id_allow_in;
    ex_allow_in_o    = ex_allow_in;
    mem_allow_in_o   = mem_allow_in;
    if_over_o        = if_over;
    id_over_o        = id_over;
    ex_over_o        = ex_over;
    mem_over_o       = mem_over;
    id_valid_o       = id_valid_q;
    ex_valid_o       = ex_valid_q;
    mem_valid_o      = mem_valid_q;
    wb_valid_o       = wb_valid_q;
    ld_id_o          = if_over & id_allow_in;
    ld_ex_o          = id_over & ex_allow_in;
    ld_mem_o         = ex_over & mem_allow_in;
    ld_wb_o          = mem_over;
    load_use_stall_o = id_valid_q & load_use;
    if_redirect_o    = fl;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^CNT_W
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(id_valid_q & load_use);
    flush_cnt_d = flush_cnt_q + CNT_W'(fl);
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: fill, load-use, flush, stalls, async reset.
module tb_pipe_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       if_ready_go_i, ex_ready_go_i, mem_ready_go_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i, ex_is_load_i, ex_flush_i;
  logic       if_allow_in_o, id_allow_in_o, ex_allow_in_o, mem_allow_in_o;
  logic       if_over_o, id_over_o, ex_over_o, mem_over_o;
  logic       id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
  logic       ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o;
  logic       load_use_stall_o, if_redirect_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_ready_go_i(if_ready_go_i), .ex_ready_go_i(ex_ready_go_i),
    .mem_ready_go_i(mem_ready_go_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .ex_flush_i(ex_flush_i),
    .if_allow_in_o(if_allow_in_o), .id_allow_in_o(id_allow_in_o),
    .ex_allow_in_o(ex_allow_in_o), .mem_allow_in_o(mem_allow_in_o),
    .if_over_o(if_over_o), .id_over_o(id_over_o),
    .ex_over_o(ex_over_o), .mem_over_o(mem_over_o),
    .id_valid_o(id_valid_o), .ex_valid_o(ex_valid_o),
    .mem_valid_o(mem_valid_o), .wb_valid_o(wb_valid_o),
    .ld_id_o(ld_id_o), .ld_ex_o(ld_ex_o), .ld_mem_o(ld_mem_o), .ld_wb_o(ld_wb_o),
    .load_use_stall_o(load_use_stall_o), .if_redirect_o(if_redirect_o)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock edge; inputs change and checks happen 1-2 time units later
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_hazard();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; ex_is_load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    if_ready_go_i = 1'b1; ex_ready_go_i = 1'b1; mem_ready_go_i = 1'b1;
    ex_flush_i = 1'b0;
    clear_hazard();
    #3;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_valids got=%b want=0000",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    total++;
    if ({if_over_o, if_allow_in_o, ld_id_o, if_redirect_o} !== 4'b0100) begin
      bad++; $display("FAIL reset_if got=%b want=0100",
                      {if_over_o, if_allow_in_o, ld_id_o, if_redirect_o});
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_v, exp_ld;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(); #1;
      exp_v  = {k >= 2, k >= 3, k >= 4, k >= 5};
      exp_ld = {1'b1, k >= 2, k >= 3, k >= 4};
      total++;
      if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== exp_v) begin
        bad++; $display("FAIL fill_valid_c%0d got=%b want=%b", k,
                        {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o}, exp_v);
      end
      total++;
      if ({ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o} !== exp_ld) begin
        bad++; $display("FAIL fill_ld_c%0d got=%b want=%b", k,
                        {ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o}, exp_ld);
      end
    end
  endtask

  task automatic test_load_use();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
    #1;
    total++;
    if ({load_use_stall_o, ld_id_o, ld_ex_o, id_allow_in_o, if_allow_in_o, ld_mem_o} !== 6'b100001) begin
      bad++; $display("FAIL lu_stall got=%b want=100001",
                      {load_use_stall_o, ld_id_o, ld_ex_o, id_allow_in_o, if_allow_in_o, ld_mem_o});
    end
    step(); #1;
    // EX now holds a bubble, so the hazard condition vanishes by itself
    total++;
    if ({load_use_stall_o, id_valid_o, ex_valid_o, mem_valid_o, ld_ex_o} !== 5'b01011) begin
      bad++; $display("FAIL lu_bubble got=%b want=01011",
                      {load_use_stall_o, id_valid_o, ex_valid_o, mem_valid_o, ld_ex_o});
    end
    clear_hazard();
    step(); #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1101) begin
      bad++; $display("FAIL lu_resume got=%b want=1101",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_no_hazard();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1;
    #1;
    total++;
    if ({load_use_stall_o, ld_ex_o} !== 2'b01) begin
      bad++; $display("FAIL rd0_nostall got=%b want=01", {load_use_stall_o, ld_ex_o});
    end
    ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b0;
    id_rs2_i = 5'd6; id_use_rs2_i = 1'b1;
    #1;
    total++;
    if (load_use_stall_o !== 1'b0) begin
      bad++; $display("FAIL unused_rs1_nostall got=%b want=0", load_use_stall_o);
    end
    id_rs2_i = 5'd5;
    #1;
    total++;
    if (load_use_stall_o !== 1'b1) begin
      bad++; $display("FAIL rs2_stall got=%b want=1", load_use_stall_o);
    end
    ex_is_load_i = 1'b0;
    #1;
    total++;
    if (load_use_stall_o !== 1'b0) begin
      bad++; $display("FAIL nonload_nostall got=%b want=0", load_use_stall_o);
    end
    clear_hazard();
  endtask

  task automatic test_flush();
    ex_flush_i = 1'b1;
    #1;
    total++;
    if (if_redirect_o !== 1'b1) begin
      bad++; $display("FAIL flush_redirect got=%b want=1", if_redirect_o);
    end
    step();
    ex_flush_i = 1'b0;
    #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b0011) begin
      bad++; $display("FAIL flush_kill got=%b want=0011",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
  endtask

  task automatic test_flush_ignored();
    ex_flush_i = 1'b1;
    #1;
    total++;
    if (if_redirect_o !== 1'b0) begin
      bad++; $display("FAIL flush_ign_redirect got=%b want=0", if_redirect_o);
    end
    step();
    ex_flush_i = 1'b0;
    #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1001) begin
      bad++; $display("FAIL flush_ign_valid got=%b want=1001",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_ex_stall();
    ex_ready_go_i = 1'b0;
    #1;
    total++;
    if ({ex_allow_in_o, id_allow_in_o, if_allow_in_o, ex_over_o, ld_mem_o, ld_ex_o, ld_id_o} !== 7'b0) begin
      bad++; $display("FAIL exst_hs got=%b want=0000000",
                      {ex_allow_in_o, id_allow_in_o, if_allow_in_o, ex_over_o, ld_mem_o, ld_ex_o, ld_id_o});
    end
    for (int c = 1; c <= 3; c++) begin
      step(); #1;
      total++;
      if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== {2'b11, 1'b0, c == 1}) begin
        bad++; $display("FAIL exst_hold_c%0d got=%b want=%b", c,
                        {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o}, {2'b11, 1'b0, c == 1});
      end
    end
    ex_ready_go_i = 1'b1;
    #1;
    total++;
    if ({ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o} !== 4'b1110) begin
      bad++; $display("FAIL exst_release_ld got=%b want=1110",
                      {ld_id_o, ld_ex_o, ld_mem_o, ld_wb_o});
    end
    step(); #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1110) begin
      bad++; $display("FAIL exst_resume got=%b want=1110",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    step();
  endtask

  task automatic test_mem_backpressure();
    mem_ready_go_i = 1'b0;
    #1;
    total++;
    if ({mem_allow_in_o, ex_allow_in_o, id_allow_in_o, if_allow_in_o, mem_over_o, ld_wb_o, ex_over_o} !== 7'b0000001) begin
      bad++; $display("FAIL membp_hs got=%b want=0000001",
                      {mem_allow_in_o, ex_allow_in_o, id_allow_in_o, if_allow_in_o, mem_over_o, ld_wb_o, ex_over_o});
    end
    step(); #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1110) begin
      bad++; $display("FAIL membp_hold got=%b want=1110",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    mem_ready_go_i = 1'b1;
    step(); #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1111) begin
      bad++; $display("FAIL membp_resume got=%b want=1111",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
  endtask

  task automatic test_flush_load_use();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
    ex_flush_i = 1'b1;
    #1;
    total++;
    if ({load_use_stall_o, if_redirect_o} !== 2'b11) begin
      bad++; $display("FAIL fllu_both got=%b want=11", {load_use_stall_o, if_redirect_o});
    end
    step();
    ex_flush_i = 1'b0;
    clear_hazard();
    #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o} !== 3'b001) begin
      bad++; $display("FAIL fllu_kill got=%b want=001", {id_valid_o, ex_valid_o, mem_valid_o});
    end
`ifdef PIPE_PERF_CNT_EN
    total++;
    if (stall_cnt_o !== 32'd2) begin
      bad++; $display("FAIL stall_cnt got=%0d want=2", stall_cnt_o);
    end
    total++;
    if (flush_cnt_o !== 32'd2) begin
      bad++; $display("FAIL flush_cnt got=%0d want=2", flush_cnt_o);
    end
`endif
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_async_reset();
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o} !== 4'b1111) begin
      bad++; $display("FAIL arst_pre got=%b want=1111",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o});
    end
    #1;
    rst_n_i = 1'b0;
    #1;
    total++;
    if ({id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o, if_over_o} !== 5'b00000) begin
      bad++; $display("FAIL arst_valids got=%b want=00000",
                      {id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o, if_over_o});
    end
`ifdef PIPE_PERF_CNT_EN
    total++;
    if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin
      bad++; $display("FAIL arst_cnt got=%0d/%0d want=0/0", stall_cnt_o, flush_cnt_o);
    end
`endif
    step();
    rst_n_i = 1'b1;
    step(); #1;
    total++;
    if ({if_over_o, id_valid_o} !== 2'b10) begin
      bad++; $display("FAIL arst_restart got=%b want=10", {if_over_o, id_valid_o});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_flush_ignored();
    test_ex_stall();
    test_mem_backpressure();
    test_flush_load_use();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
